// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable constants and small decode helpers.
package lsu_pkg;

    // RISC-V load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RISC-V store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte-enable patterns
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // A request is legal when funct3 names a real load/store and the address
    // is naturally aligned for the access size.
    function automatic logic lsu_is_legal(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic known;
        logic aligned;
        if (we) begin
            known = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            known = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        case (funct3[1:0])
            2'b01:   aligned = (addr_lo[0] == 1'b0);
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return known && aligned;
    endfunction

    // Byte lanes touched by an access; identical for loads and stores.
    function automatic logic [3:0] lsu_byte_enable(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = BE_BYTE0 << addr_lo;
            2'b01:   be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to the load funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] din,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] dout
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension to a full word
    always_comb begin
        byte_lane = din[{addr, 3'b000} +: 8];
        half_lane = din[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   dout = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   dout = {{16{half_lane[15]}}, half_lane};
            F3_LW:   dout = din;
            F3_LBU:  dout = {24'h000000, byte_lane};
            F3_LHU:  dout = {16'h0000, half_lane};
            default: dout = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store controller: accepts one request at a time, checks alignment,
// drives a single-outstanding memory handshake with timeout, and returns
// extended load data with a one-cycle response pulse.
module load_store_ctrl
    import lsu_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int MAX_WAIT    = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [WORD_LENGTH-1:0] req_addr,
    input  logic [WORD_LENGTH-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [WORD_LENGTH-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   stall,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic                   mem_ack,
    input  logic [WORD_LENGTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    lsu_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   we_q, we_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [WORD_LENGTH-1:0] addr_q, addr_d;
    logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
    logic [WORD_LENGTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;
    logic                   req_legal;
    logic                   timeout;
    logic [31:0]            ext_dout;

    assign req_legal = lsu_is_legal(req_we, req_funct3, req_addr[1:0]);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign timeout   = (cnt_inc == CNT_W'(MAX_WAIT));

    lsu_extend u_extend (
        .din    (mem_rdata[31:0]),
        .addr   (addr_q[1:0]),
        .funct3 (funct3_q),
        .dout   (ext_dout)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and wait counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = req_legal ? ST_ACCESS : ST_RESP;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and pipeline-hold outputs decoded from the current state
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_req    = (state_q == ST_ACCESS);
        resp_valid = (state_q == ST_RESP);
        stall      = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_ACCESS);
    end

    // Request latch and response data/error capture
    always_comb begin
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if ((state_q == ST_IDLE) && req_valid) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            if (!req_legal) begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
            end
        end else if (state_q == ST_ACCESS) begin
            if (mem_ack) begin
                resp_rdata_d = we_q ? '0 : WORD_LENGTH'(ext_dout);
                resp_err_d   = 1'b0;
            end else if (timeout) begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
            end
        end
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory-side request fields derived from the latched request
    always_comb begin
        mem_we   = we_q;
        mem_addr = {addr_q[WORD_LENGTH-1:2], 2'b00};
        mem_be   = lsu_byte_enable(funct3_q, addr_q[1:0]);
        case (funct3_q[1:0])
            2'b00:   mem_wdata = WORD_LENGTH'({4{wdata_q[7:0]}});
            2'b01:   mem_wdata = WORD_LENGTH'({2{wdata_q[15:0]}});
            default: mem_wdata = wdata_q;
        endcase
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed self-checking bench for load_store_ctrl. Inputs change on the
// falling edge and outputs are sampled 1 ns later, so each apply_stimulus
// call is one clock cycle.
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int check_count = 0;
    int error_count = 0;

    // 10 ns free-running clock
    always #5 clk = ~clk;

    load_store_ctrl #(
        .WORD_LENGTH (32),
        .MAX_WAIT    (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic apply_stimulus(input logic        valid,
                                  input logic        we,
                                  input logic [2:0]  f3,
                                  input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  input logic        ack,
                                  input logic [31:0] rdata);
        @(negedge clk);
        req_valid  = valid;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_ack    = ack;
        mem_rdata  = rdata;
        #1;
    endtask

    task automatic apply_idle(input logic ack, input logic [31:0] rdata);
        apply_stimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, ack, rdata);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        // Reset state
        apply_idle(1'b0, 32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("rst_mem_req",    32'(mem_req),    32'h0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_output("rst_resp_err",   32'(resp_err),   32'h0);
        check_output("rst_resp_rdata", resp_rdata,      32'h0);
        check_output("rst_req_ready",  32'(req_ready),  32'h1);
        check_output("rst_stall",      32'(stall),      32'h0);
        rst_n = 1'b1;

        // LB 0x103 with one-cycle ack: sign-extended 0x80
        apply_stimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b0, 32'h0);
        check_output("lb_accept_ready", 32'(req_ready), 32'h1);
        check_output("lb_accept_stall", 32'(stall),     32'h1);
        check_output("lb_accept_memreq", 32'(mem_req),  32'h0);
        apply_idle(1'b1, 32'h80FF_1234);
        check_output("lb_mem_req",   32'(mem_req),    32'h1);
        check_output("lb_mem_addr",  mem_addr,        32'h0000_0100);
        check_output("lb_mem_be",    32'(mem_be),     32'h8);
        check_output("lb_mem_we",    32'(mem_we),     32'h0);
        check_output("lb_busy_ready", 32'(req_ready), 32'h0);
        check_output("lb_busy_stall", 32'(stall),     32'h1);
        check_output("lb_early_resp", 32'(resp_valid), 32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("lb_resp_valid", 32'(resp_valid), 32'h1);
        check_output("lb_resp_rdata", resp_rdata,      32'hFFFF_FF80);
        check_output("lb_resp_err",   32'(resp_err),   32'h0);
        check_output("lb_resp_stall", 32'(stall),      32'h0);
        check_output("lb_resp_ready", 32'(req_ready),  32'h0);
        check_output("lb_resp_memreq", 32'(mem_req),   32'h0);

        // LHU 0x102: upper half zero-extended; previous data held meanwhile
        apply_stimulus(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 1'b0, 32'h0);
        check_output("lhu_pulse_once", 32'(resp_valid), 32'h0);
        check_output("lb_rdata_hold",  resp_rdata,      32'hFFFF_FF80);
        apply_idle(1'b1, 32'h8001_0000);
        check_output("lhu_mem_be",   32'(mem_be), 32'hC);
        check_output("lhu_mem_addr", mem_addr,    32'h0000_0100);
        apply_idle(1'b0, 32'h0);
        check_output("lhu_resp_valid", 32'(resp_valid), 32'h1);
        check_output("lhu_resp_rdata", resp_rdata,      32'h0000_8001);

        // LW 0x002 misaligned: immediate error response, no memory request
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 1'b0, 32'h0);
        check_output("lwmis_ready", 32'(req_ready), 32'h1);
        check_output("lwmis_stall", 32'(stall),     32'h1);
        apply_idle(1'b0, 32'h0);
        check_output("lwmis_mem_req",    32'(mem_req),    32'h0);
        check_output("lwmis_resp_valid", 32'(resp_valid), 32'h1);
        check_output("lwmis_resp_err",   32'(resp_err),   32'h1);
        check_output("lwmis_resp_rdata", resp_rdata,      32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("lwmis_pulse_once", 32'(resp_valid), 32'h0);
        check_output("lwmis_err_hold",   32'(resp_err),   32'h1);
        check_output("idle_stall",       32'(stall),      32'h0);

        // Stray ack while idle must be ignored
        apply_idle(1'b1, 32'h1234_5678);
        apply_idle(1'b0, 32'h0);
        check_output("stray_ack_resp",   32'(resp_valid), 32'h0);
        check_output("stray_ack_memreq", 32'(mem_req),    32'h0);

        // SB 0x201: byte replicated across lanes, rdata forced to zero
        apply_stimulus(1'b1, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 1'b0, 32'h0);
        apply_idle(1'b1, 32'hDEAD_BEEF);
        check_output("sb_mem_we",    32'(mem_we), 32'h1);
        check_output("sb_mem_be",    32'(mem_be), 32'h2);
        check_output("sb_mem_wdata", mem_wdata,   32'hABAB_ABAB);
        check_output("sb_mem_addr",  mem_addr,    32'h0000_0200);
        apply_idle(1'b0, 32'h0);
        check_output("sb_resp_valid", 32'(resp_valid), 32'h1);
        check_output("sb_resp_rdata", resp_rdata,      32'h0);
        check_output("sb_resp_err",   32'(resp_err),   32'h0);

        // SH 0x101 misaligned: error response
        apply_stimulus(1'b1, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_1234, 1'b0, 32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("shmis_resp_valid", 32'(resp_valid), 32'h1);
        check_output("shmis_resp_err",   32'(resp_err),   32'h1);
        check_output("shmis_mem_req",    32'(mem_req),    32'h0);

        // Store with an undefined funct3 is illegal
        apply_stimulus(1'b1, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("badf3_resp_err", 32'(resp_err), 32'h1);
        check_output("badf3_mem_req",  32'(mem_req),  32'h0);

        // SH 0x00A: halfword replicated, upper lanes enabled
        apply_stimulus(1'b1, 1'b1, 3'b001, 32'h0000_000A, 32'h1234_5678, 1'b0, 32'h0);
        apply_idle(1'b1, 32'h0);
        check_output("sh_mem_wdata", mem_wdata,   32'h5678_5678);
        check_output("sh_mem_be",    32'(mem_be), 32'hC);
        check_output("sh_mem_addr",  mem_addr,    32'h0000_0008);
        apply_idle(1'b0, 32'h0);
        check_output("sh_resp_err",  32'(resp_err), 32'h0);

        // LH 0x006 with one wait cycle: sign-extended upper half
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0, 1'b0, 32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("lh_wait_memreq", 32'(mem_req),    32'h1);
        check_output("lh_wait_resp",   32'(resp_valid), 32'h0);
        apply_idle(1'b1, 32'h8765_4321);
        check_output("lh_ack_memreq",  32'(mem_req), 32'h1);
        apply_idle(1'b0, 32'h0);
        check_output("lh_resp_valid",  32'(resp_valid), 32'h1);
        check_output("lh_resp_rdata",  resp_rdata,      32'hFFFF_8765);

        // SW 0x300 never acknowledged: 15 request cycles, then timeout error
        apply_stimulus(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            apply_idle(1'b0, 32'h0);
            check_output($sformatf("sw_to_memreq_%0d", i), 32'(mem_req),    32'h1);
            check_output($sformatf("sw_to_resp_%0d", i),   32'(resp_valid), 32'h0);
            if (i == 0) begin
                check_output("sw_mem_wdata", mem_wdata,   32'h1122_3344);
                check_output("sw_mem_be",    32'(mem_be), 32'hF);
            end
        end
        apply_idle(1'b0, 32'h0);
        check_output("sw_to_resp_valid", 32'(resp_valid), 32'h1);
        check_output("sw_to_resp_err",   32'(resp_err),   32'h1);
        check_output("sw_to_mem_req",    32'(mem_req),    32'h0);
        check_output("sw_to_resp_rdata", resp_rdata,      32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("sw_to_pulse_once", 32'(resp_valid), 32'h0);

        // Reset in the middle of an access aborts it silently
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
        apply_idle(1'b0, 32'h0);
        check_output("abort_pre_memreq", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        check_output("abort_memreq_drop", 32'(mem_req),    32'h0);
        check_output("abort_no_resp",     32'(resp_valid), 32'h0);
        check_output("abort_err_clear",   32'(resp_err),   32'h0);
        apply_idle(1'b0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_idle(1'b1, 32'hCAFE_F00D);
            check_output($sformatf("abort_late_ack_resp_%0d", i), 32'(resp_valid), 32'h0);
            check_output($sformatf("abort_late_ack_req_%0d", i),  32'(mem_req),    32'h0);
        end
        apply_idle(1'b0, 32'h0);
        check_output("abort_after_resp", 32'(resp_valid), 32'h0);
        check_output("abort_ready",      32'(req_ready),  32'h1);

        // Normal LBU 0x041 after the aborted transaction
        apply_stimulus(1'b1, 1'b0, 3'b100, 32'h0000_0041, 32'h0, 1'b0, 32'h0);
        apply_idle(1'b1, 32'h0000_F500);
        check_output("lbu_mem_addr", mem_addr,    32'h0000_0040);
        check_output("lbu_mem_be",   32'(mem_be), 32'h2);
        apply_idle(1'b0, 32'h0);
        check_output("lbu_resp_valid", 32'(resp_valid), 32'h1);
        check_output("lbu_resp_rdata", resp_rdata,      32'h0000_00F5);
        check_output("lbu_resp_err",   32'(resp_err),   32'h0);
        apply_idle(1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
